// File: rtl/cfg_loader.sv
// Config fetch stage: handshakes one read with the off-chip config interface and captures
// NUM_WORDS words for the CCU. Optional trailing-XOR check with retries: CFG_LOADER_CHECKSUM_EN.
module cfg_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            CFG_Req,
  output logic                            IFCFG_Req,
  input  logic                            IFCFG_Ack,
  input  logic                            IFCFG_Val,
  input  logic [DATA_WIDTH-1:0]           IFCFG_Dat,
  output logic                            IFCFG_RdDone,
  output logic                            CFG_Vld,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] CFG_Words,
  output logic                            CFG_Err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_RECV    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_WAITLOW = 3'd4;

  if (NUM_WORDS < 2 || (2 ** CNT_WIDTH) <= NUM_WORDS || MAX_RETRY < 0) begin : g_bad_params
    $error("cfg_loader: illegal parameter combination");
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  // The checksum word arrives at index NUM_WORDS and is compared, never stored.
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(NUM_WORDS);
  localparam int                   RETRY_W   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
`else
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(NUM_WORDS - 1);
`endif

  logic [2:0]                      state_q, state_d;
  logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
  logic [NUM_WORDS*DATA_WIDTH-1:0] words_q, words_d;
  logic                            ifcfgReq_q, ifcfgReq_d;
  logic                            rdDone_q, rdDone_d;
  logic                            vld_q, vld_d;
  logic                            err_q, err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    ifcfgReq_d = ifcfgReq_q;
    rdDone_d   = 1'b0;
    vld_d      = vld_q;
    err_d      = err_q;
`ifdef CFG_LOADER_CHECKSUM_EN
    retry_d    = retry_q;
    xor_d      = xor_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (CFG_Req) begin
          state_d    = S_REQ;
          ifcfgReq_d = 1'b1;
          vld_d      = 1'b0;
          err_d      = 1'b0;
          cnt_d      = '0;
`ifdef CFG_LOADER_CHECKSUM_EN
          retry_d    = '0;
          xor_d      = '0;
`endif
        end
      end

      S_REQ: begin
        if (!CFG_Req) begin
          state_d    = S_IDLE;
          ifcfgReq_d = 1'b0;
          vld_d      = 1'b0;
          err_d      = 1'b1;
        end else if (IFCFG_Ack) begin
          state_d    = S_RECV;
          ifcfgReq_d = 1'b0;
        end
      end

      S_RECV: begin
        // Dropping the request mid-load aborts; words already written are left as-is.
        if (!CFG_Req) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
          err_d   = 1'b1;
        end else if (IFCFG_Val) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
              words_d[k*DATA_WIDTH +: DATA_WIDTH] = IFCFG_Dat;
            end
          end
          cnt_d = cnt_q + 1'b1;
`ifdef CFG_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ IFCFG_Dat;
          if (cnt_q == LAST_IDX) begin
            if (IFCFG_Dat == xor_q) begin
              state_d  = S_DONE;
              rdDone_d = 1'b1;
              vld_d    = 1'b1;
            end else if (retry_q == RETRY_MAX) begin
              state_d  = S_DONE;
              rdDone_d = 1'b1;
              vld_d    = 1'b0;
              err_d    = 1'b1;
            end else begin
              state_d    = S_REQ;
              ifcfgReq_d = 1'b1;
              retry_d    = retry_q + 1'b1;
              cnt_d      = '0;
              xor_d      = '0;
            end
          end
`else
          if (cnt_q == LAST_IDX) begin
            state_d  = S_DONE;
            rdDone_d = 1'b1;
            vld_d    = 1'b1;
          end
`endif
        end
      end

      S_DONE: begin
        state_d = S_WAITLOW;
      end

      // Hold here until the CCU drops its level request so one request gives one load.
      S_WAITLOW: begin
        if (!CFG_Req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        ifcfgReq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      words_q    <= '0;
      ifcfgReq_q <= 1'b0;
      rdDone_q   <= 1'b0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      retry_q    <= '0;
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      ifcfgReq_q <= ifcfgReq_d;
      rdDone_q   <= rdDone_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
`ifdef CFG_LOADER_CHECKSUM_EN
      retry_q    <= retry_d;
      xor_q      <= xor_d;
`endif
    end
  end

  assign IFCFG_Req    = ifcfgReq_q;
  assign IFCFG_RdDone = rdDone_q;
  assign CFG_Vld      = vld_q;
  assign CFG_Err      = err_q;
  assign CFG_Words    = words_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboard bench for cfg_loader: expected words are queued as they are driven and
// compared when IFCFG_RdDone pulses; the checksum scenarios follow CFG_LOADER_CHECKSUM_EN.
module tb_cfg_loader;

  localparam int DW        = 32;
  localparam int NW        = 8;
  localparam int CW        = 4;
  localparam int MAX_RETRY = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfgReq;
  logic             ifcfgReq;
  logic             ifcfgAck;
  logic             ifcfgVal;
  logic [DW-1:0]    ifcfgDat;
  logic             ifcfgRdDone;
  logic             cfgVld;
  logic [NW*DW-1:0] cfgWords;
  logic             cfgErr;

  int checks    = 0;
  int failures  = 0;
  int hsCount   = 0;
  int doneCount = 0;

  logic [DW-1:0] expQ [$];
  logic [DW-1:0] shadow [NW];
  logic [DW-1:0] loadWords [NW];

  always #5 clk = ~clk;

  cfg_loader #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW),
    .CNT_WIDTH (CW),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .CFG_Req     (cfgReq),
    .IFCFG_Req   (ifcfgReq),
    .IFCFG_Ack   (ifcfgAck),
    .IFCFG_Val   (ifcfgVal),
    .IFCFG_Dat   (ifcfgDat),
    .IFCFG_RdDone(ifcfgRdDone),
    .CFG_Vld     (cfgVld),
    .CFG_Words   (cfgWords),
    .CFG_Err     (cfgErr)
  );

  // Count accepted request handshakes and done pulses independently of the stimulus flow.
  always @(posedge clk) begin
    if (!rst && ifcfgReq && ifcfgAck) hsCount <= hsCount + 1;
    if (ifcfgRdDone) doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [NW*DW-1:0] observed,
                             input logic [NW*DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NW*DW-1:0] packShadow();
    logic [NW*DW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*DW +: DW] = shadow[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [DW-1:0] d);
    ifcfgVal = 1'b1;
    ifcfgDat = d;
    tick();
    ifcfgVal = 1'b0;
    ifcfgDat = '0;
  endtask

  task automatic dropReq();
    cfgReq = 1'b0;
    tick();
    tick();
  endtask

  // One complete load of loadWords; badTries leading attempts carry a corrupt checksum.
  task automatic applyStimulus(input int gap, input int ackDelay, input int badTries,
                               input bit expErr);
    int            tries;
    int            hs0;
    int            done0;
    logic [DW-1:0] cks;
    logic [DW-1:0] expWord;
    tries = (badTries > MAX_RETRY) ? MAX_RETRY + 1 : badTries + 1;
`ifndef CFG_LOADER_CHECKSUM_EN
    tries = 1;
`endif
    hs0   = hsCount;
    done0 = doneCount;
    cfgReq = 1'b1;
    tick();
    checkOutput("req_rise", ifcfgReq, 1'b1);
    checkOutput("vld_clear", cfgVld, 1'b0);
    checkOutput("err_clear", cfgErr, 1'b0);
    for (int t = 0; t < tries; t++) begin
      repeat (ackDelay) tick();
      checkOutput("req_hold", ifcfgReq, 1'b1);
      ifcfgAck = 1'b1;
      ifcfgVal = 1'b1;
      ifcfgDat = 32'hBAD0_BAD0;
      tick();
      ifcfgAck = 1'b0;
      ifcfgVal = 1'b0;
      checkOutput("req_drop", ifcfgReq, 1'b0);
      cks = '0;
      for (int i = 0; i < NW; i++) begin
        repeat (gap) tick();
        if (t == tries - 1) expQ.push_back(loadWords[i]);
        shadow[i] = loadWords[i];
        cks ^= loadWords[i];
        sendWord(loadWords[i]);
      end
`ifdef CFG_LOADER_CHECKSUM_EN
      repeat (gap) tick();
      sendWord((t < badTries) ? (cks ^ 32'h0000_0001) : cks);
      if (t < tries - 1) begin
        checkOutput("retry_req", ifcfgReq, 1'b1);
        checkOutput("retry_nodone", ifcfgRdDone, 1'b0);
      end
`endif
    end
    checkOutput("rddone_pulse", ifcfgRdDone, 1'b1);
    checkOutput("vld_done", cfgVld, !expErr);
    checkOutput("err_done", cfgErr, expErr);
    for (int i = 0; i < NW; i++) begin
      expWord = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      checkOutput("word", cfgWords[i*DW +: DW], expWord);
    end
    tick();
    checkOutput("rddone_low", ifcfgRdDone, 1'b0);
    checkOutput("vld_hold", cfgVld, !expErr);
    checkOutput("handshakes", hsCount - hs0, tries);
    checkOutput("done_count", doneCount - done0, 1);
  endtask

  initial begin
    int reqHighs;
    int done0;
    rst      = 1'b1;
    cfgReq   = 1'b0;
    ifcfgAck = 1'b0;
    ifcfgVal = 1'b0;
    ifcfgDat = '0;
    for (int i = 0; i < NW; i++) shadow[i] = '0;
    tick();
    tick();
    checkOutput("rst_req", ifcfgReq, 1'b0);
    checkOutput("rst_done", ifcfgRdDone, 1'b0);
    checkOutput("rst_vld", cfgVld, 1'b0);
    checkOutput("rst_err", cfgErr, 1'b0);
    checkOutput("rst_words", cfgWords, '0);
    rst = 1'b0;
    tick();

    // Back-to-back load of 0x11..0x88 with ack two cycles after the request.
    for (int i = 0; i < NW; i++) loadWords[i] = 32'h11 * (i + 1);
    applyStimulus(0, 2, 0, 1'b0);
    checkOutput("word0", cfgWords[DW-1:0], 32'h11);
    checkOutput("word7", cfgWords[NW*DW-1 -: DW], 32'h88);

    // Request held high after done must not retrigger.
    reqHighs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifcfgReq) reqHighs++;
    end
    checkOutput("no_retrigger", reqHighs, 0);
    dropReq();

    // Same words with a valid every third cycle.
    applyStimulus(2, 1, 0, 1'b0);
    dropReq();

    // Abort after three words.
    done0 = doneCount;
    cfgReq = 1'b1;
    tick();
    checkOutput("abort_vld_entry", cfgVld, 1'b0);
    tick();
    ifcfgAck = 1'b1;
    tick();
    ifcfgAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shadow[i] = 32'hA1 + i;
      sendWord(32'hA1 + i);
    end
    cfgReq = 1'b0;
    tick();
    checkOutput("abort_req", ifcfgReq, 1'b0);
    checkOutput("abort_done", ifcfgRdDone, 1'b0);
    checkOutput("abort_vld", cfgVld, 1'b0);
    checkOutput("abort_err", cfgErr, 1'b1);
    repeat (3) sendWord(32'hDEAD_BEEF);
    checkOutput("abort_words", cfgWords, packShadow());
    checkOutput("abort_nodone", doneCount - done0, 0);
    checkOutput("abort_err_sticky", cfgErr, 1'b1);

    // Reset in the middle of a load, on the fifth word.
    cfgReq = 1'b1;
    tick();
    tick();
    ifcfgAck = 1'b1;
    tick();
    ifcfgAck = 1'b0;
    for (int i = 0; i < 4; i++) sendWord(32'h1000 + i);
    ifcfgVal = 1'b1;
    ifcfgDat = 32'h1004;
    rst      = 1'b1;
    tick();
    ifcfgVal = 1'b0;
    rst      = 1'b0;
    cfgReq   = 1'b0;
    for (int i = 0; i < NW; i++) shadow[i] = '0;
    checkOutput("midrst_req", ifcfgReq, 1'b0);
    checkOutput("midrst_done", ifcfgRdDone, 1'b0);
    checkOutput("midrst_vld", cfgVld, 1'b0);
    checkOutput("midrst_err", cfgErr, 1'b0);
    checkOutput("midrst_words", cfgWords, packShadow());
    tick();
    for (int i = 0; i < NW; i++) loadWords[i] = 32'hC0 + i;
    applyStimulus(0, 1, 0, 1'b0);
    dropReq();

`ifdef CFG_LOADER_CHECKSUM_EN
    // Every checksum wrong: give up after MAX_RETRY retries, then a load that recovers.
    for (int i = 0; i < NW; i++) loadWords[i] = 32'h5500_0000 + 32'h0101 * i;
    applyStimulus(0, 1, 4, 1'b1);
    dropReq();
    applyStimulus(1, 0, 1, 1'b0);
    dropReq();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
